// File: rtl/fp_composer.sv
// Composes a packed IEEE-754 double from sign, unbiased exponent and a 57-bit
// fixed-point mantissa: one normalise step per cycle, then round-to-nearest-even.
module fp_composer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [11:0] in_exponent,
  input  logic [56:0] in_mantissa,
  input  logic        in_is_nan,
  input  logic        in_is_inf,
  input  logic        in_is_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] fp_out,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  typedef enum logic [1:0] {IDLE, ALIGN, ROUND, OUT} state_t;

  localparam logic signed [12:0] E_MIN   = -13'sd1022;
  localparam logic signed [12:0] E_MAX   = 13'sd1023;
  localparam logic signed [12:0] E_FLUSH = -13'sd1080;
  localparam logic [63:0]        QNAN    = 64'h7FF8_0000_0000_0000;

  state_t             r_state, w_state_nxt;
  logic signed [12:0] r_e, w_e_nxt;
  logic        [56:0] r_m, w_m_nxt;
  logic               r_sign, w_sign_nxt;
  logic        [63:0] r_fp, w_fp_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_unf, w_unf_nxt;
  logic               r_inx, w_inx_nxt;

  // Rounding datapath, consumed only in ROUND.
  logic               w_round_up;
  logic        [56:0] w_m_sum;
  logic        [56:0] w_m_rnd;
  logic signed [12:0] w_e_rnd;
  logic        [10:0] w_exp_field;
  logic               w_rnd_inexact;
  logic               w_tiny;

  assign w_round_up    = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
  assign w_m_sum       = r_m + (w_round_up ? 57'd8 : 57'd0);
  assign w_m_rnd       = w_m_sum[56] ? {1'b0, w_m_sum[56:1]} : w_m_sum;
  assign w_e_rnd       = w_m_sum[56] ? r_e + 13'sd1 : r_e;
  // Modulo-2^11 add is exact for every normal exponent in [-1022, 1023].
  assign w_exp_field   = w_m_rnd[55] ? (w_e_rnd[10:0] + 11'd1023) : 11'd0;
  assign w_rnd_inexact = |r_m[2:0];
  assign w_tiny        = (w_exp_field == 11'd0) && (r_m[54:0] != 55'd0);

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == OUT);
  assign fp_out    = r_fp;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign inexact   = r_inx;

  always_comb begin
    // NOTE: every next-state value is defaulted to its register first so no
    // path through the case leaves a variable unassigned (no latches).
    w_state_nxt = r_state;
    w_e_nxt     = r_e;
    w_m_nxt     = r_m;
    w_sign_nxt  = r_sign;
    w_fp_nxt    = r_fp;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_inx_nxt   = r_inx;

    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_sign_nxt = in_sign;
          w_e_nxt    = {in_exponent[11], in_exponent};
          w_m_nxt    = in_mantissa;
          w_ovf_nxt  = 1'b0;
          w_unf_nxt  = 1'b0;
          w_inx_nxt  = 1'b0;
          if (in_is_nan) begin
            w_fp_nxt    = QNAN;
            w_state_nxt = OUT;
          end else if (in_is_inf) begin
            w_fp_nxt    = {in_sign, 11'h7FF, 52'd0};
            w_state_nxt = OUT;
          end else if (in_is_zero || (in_mantissa == 57'd0)) begin
            w_fp_nxt    = {in_sign, 63'd0};
            w_state_nxt = OUT;
          end else begin
            w_state_nxt = ALIGN;
          end
        end
      end

      ALIGN: begin
        if (r_m[56]) begin
          w_m_nxt = {1'b0, r_m[56:2], r_m[1] | r_m[0]};
          w_e_nxt = r_e + 13'sd1;
        end else if (r_e < E_FLUSH) begin
          w_m_nxt = {56'd0, |r_m};
          w_e_nxt = E_MIN;
        end else if (r_e < E_MIN) begin
          w_m_nxt = {1'b0, r_m[56:2], r_m[1] | r_m[0]};
          w_e_nxt = r_e + 13'sd1;
        end else if (!r_m[55] && (r_e > E_MIN)) begin
          w_m_nxt = {r_m[55:0], 1'b0};
          w_e_nxt = r_e - 13'sd1;
        end else begin
          w_state_nxt = ROUND;
        end
      end

      ROUND: begin
        w_m_nxt     = w_m_rnd;
        w_e_nxt     = w_e_rnd;
        w_state_nxt = OUT;
        if (w_e_rnd > E_MAX) begin
          w_fp_nxt  = {r_sign, 11'h7FF, 52'd0};
          w_ovf_nxt = 1'b1;
          w_unf_nxt = 1'b0;
          w_inx_nxt = 1'b1;
        end else begin
          w_fp_nxt  = {r_sign, w_exp_field, w_m_rnd[54:3]};
          w_ovf_nxt = 1'b0;
          w_unf_nxt = w_tiny & w_rnd_inexact;
          w_inx_nxt = w_rnd_inexact;
        end
      end

      OUT: begin
        if (out_ready) w_state_nxt = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_e     <= '0;
      r_m     <= '0;
      r_sign  <= 1'b0;
      r_fp    <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_inx   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_e     <= w_e_nxt;
      r_m     <= w_m_nxt;
      r_sign  <= w_sign_nxt;
      r_fp    <= w_fp_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
      r_inx   <= w_inx_nxt;
    end
  end

endmodule

// File: doc/fp_composer.md
FP_COMPOSER -- requirements
Module: fp_composer

Interface
REQ-001 SHALL have no parameters; the double-precision format is fixed: 1 sign bit, 11 exponent bits, 52 fraction bits, bias 1023.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  input operand present.
REQ-005 in_ready  output  1  block can accept an operand.
REQ-006 in_sign  input  1  result sign.
REQ-007 in_exponent  input  12  signed two's-complement unbiased exponent.
REQ-008 in_mantissa  input  57  unsigned; value = in_mantissa / 2^55 * 2^in_exponent; bit 56 is overflow, bit 55 is the integer bit, bits 54:0 are fraction.
REQ-009 in_is_nan, in_is_inf, in_is_zero  input  1 each  special-value flags; priority is nan > inf > zero.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 fp_out  output  64  packed IEEE-754 double.
REQ-013 overflow, underflow, inexact  output  1 each  exception flags for fp_out; valid while out_valid=1.

Function
REQ-014 The FSM SHALL have states IDLE, ALIGN, ROUND and OUT; in_ready SHALL be 1 only in IDLE.
REQ-015 An accept (in_valid and in_ready high at an edge) SHALL capture all inputs into a 13-bit signed exponent register e and a 57-bit register m.
- Specials go to OUT.
- Everything else goes to ALIGN.
REQ-016 Special results:
- NaN: 0x7FF8000000000000, sign ignored.
- Inf: {sign, 0x7FF, 0}.
- Zero, or non-special with in_mantissa = 0: {sign, 63'b0}.
- All flags 0 for these results.
REQ-017 ALIGN SHALL perform at most one action per cycle, in this priority order:
- (a) If m[56]=1: shift m right 1, OR the lost bit into m[0], e += 1.
- (b) Else if e < -1022-58: set m = {56'b0, OR(m)}, e = -1022.
- (c) Else if e < -1022: shift right 1 with sticky into m[0], e += 1.
- (d) Else if m[55]=0 and e > -1022: shift m left 1, e -= 1.
- (e) Else: go to ROUND.
REQ-018 ROUND SHALL use round-to-nearest-even on guard m[2], round m[1], sticky m[0]:
- Round up when m[2] and (m[1] or m[0] or m[3]).
- Rounding up adds 8 to m.
- If the add carries into m[56], shift right 1 and e += 1.
- inexact = m[2] | m[1] | m[0], taken before rounding.
REQ-019 Packing in ROUND, registered into fp_out on the transition to OUT:
- If e > 1023: fp_out = {sign, 0x7FF, 0}, overflow=1, inexact=1.
- Else if m[55]=1: biased exponent = e + 1023.
- Else: biased exponent = 0 (denormal).
- Fraction = m[54:3].
- underflow = (result biased exponent 0 and nonzero fraction before rounding) and inexact.
REQ-020 Latency from accept edge to out_valid high:
- Specials: 1 cycle.
- Others: (number of ALIGN shift cycles) + 3 cycles.
REQ-021 In OUT, out_valid=1, and fp_out and the flags SHALL stay stable until out_ready=1 at an edge; the FSM then returns to IDLE. out_ready while not in OUT has no effect.
REQ-022 No new operand SHALL be accepted while a result is pending; back-to-back operation is not required.

Reset
REQ-023 On rst_n low, asynchronously:
- state = IDLE.
- in_ready=1 (combinational from state).
- out_valid=0, fp_out=0, overflow=0, underflow=0, inexact=0.
- e=0, m=0.
REQ-024 Reset asserted mid-operation SHALL abandon the in-flight operand with no output produced; the first edge after rst_n rises SHALL accept a new operand.

Verification
REQ-025 exp=0, mant=1<<55, sign=0 -> fp_out=0x3FF0000000000000, out_valid 3 cycles after accept, flags 0.
REQ-026 exp=0, mant=1<<53 -> two left shifts, fp_out=0x3FD0000000000000, out_valid 5 cycles after accept.
REQ-027 exp=1023, mant=0x0FFFFFFFFFFFFFF (bits 55:0 all ones) -> round carry, e=1024, fp_out=0x7FF0000000000000, overflow=1, inexact=1.
REQ-028 exp=-1023, mant=1<<55 -> fp_out=0x0008000000000000, underflow=0, inexact=0; exp=-2000, mant=1 -> fp_out=0x0000000000000000, underflow=1, inexact=1.
REQ-029 in_is_nan=1, sign=1 -> fp_out=0x7FF8000000000000 after 1 cycle; hold out_ready=0 for 5 cycles -> out_valid, fp_out and in_ready=0 stay stable.
REQ-030 Pull rst_n low during ALIGN of a 2-shift operand -> out_valid stays 0, in_ready=1 immediately; the next operand completes per REQ-025.
